// File: rtl/pwm_hbridge_ramp.sv
// H-bridge PWM driver with a per-frame duty slew limit and a dead-time interlock on reversal.
// state | meaning: OFF = unpowered, outputs 00 | RUN = PWM drive | BRAKE = both low sides on (11) | DEAD = 00 gap before reversal
module pwm_hbridge_ramp #(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 20,
    parameter int RAMP_STEP   = 8,
    parameter int DEAD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             power,
    input  logic             clockwise,
    input  logic             n_brake,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic             motor_a,
    output logic             motor_b,
    output logic [WIDTH-1:0] duty_eff,
    output logic             frame_start,
    output logic             dead
);

    localparam int PW = WIDTH + $clog2(PRESCALE) + 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [WIDTH-1:0] SLOT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [PW-1:0]    PRESC     = PW'(PRESCALE);
    localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    localparam logic [31:0]      RSTEP     = 32'(RAMP_STEP);

    typedef enum logic [1:0] {S_OFF, S_RUN, S_BRAKE, S_DEAD} state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] slot_q, slot_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_eff_q, duty_eff_d;
    logic [DW-1:0]    dead_cnt_q, dead_cnt_d;
    logic [1:0]       motor_q, motor_d;
    logic             frame_start_q, frame_start_d;
    logic             dead_q, dead_d;

    logic [WIDTH-1:0] period_nz;
    logic [PW-1:0]    slot_len;
    logic             slot_end;
    logic [WIDTH-1:0] ramp_diff, ramp_step, ramped;
    logic             new_frame;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= S_OFF;
            dir_q         <= 1'b0;
            presc_q       <= '0;
            slot_q        <= '0;
            period_q      <= '0;
            duty_eff_q    <= '0;
            dead_cnt_q    <= '0;
            motor_q       <= 2'b00;
            frame_start_q <= 1'b0;
            dead_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            presc_q       <= presc_d;
            slot_q        <= slot_d;
            period_q      <= period_d;
            duty_eff_q    <= duty_eff_d;
            dead_cnt_q    <= dead_cnt_d;
            motor_q       <= motor_d;
            frame_start_q <= frame_start_d;
            dead_q        <= dead_d;
        end
    end

    always_comb begin
        period_nz = (period_q == '0) ? WIDTH'(1) : period_q;
        slot_len  = PW'(period_nz) * PRESC;
        slot_end  = (presc_q == slot_len - 1'b1);
    end

    // Step toward the target by at most RAMP_STEP; the clamp to the remaining distance prevents overshoot.
    always_comb begin
        ramp_diff = (duty >= duty_eff_q) ? (duty - duty_eff_q) : (duty_eff_q - duty);
        ramp_step = (32'(ramp_diff) > RSTEP) ? RSTEP[WIDTH-1:0] : ramp_diff;
        if (RAMP_STEP == 0) begin
            ramped = duty;
        end else if (duty >= duty_eff_q) begin
            ramped = duty_eff_q + ramp_step;
        end else begin
            ramped = duty_eff_q - ramp_step;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!power) begin
            state_d = S_OFF;
        end else if (!n_brake) begin
            state_d = S_BRAKE;
        end else begin
            case (state_q)
                S_OFF, S_BRAKE: state_d = S_RUN;
                S_RUN:          state_d = (clockwise != dir_q) ? S_DEAD : S_RUN;
                S_DEAD:         state_d = (dead_cnt_q == '0) ? S_RUN : S_DEAD;
                default:        state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        dir_d         = clockwise;
        presc_d       = '0;
        slot_d        = '0;
        period_d      = period_q;
        duty_eff_d    = '0;
        dead_cnt_d    = '0;
        motor_d       = 2'b00;
        frame_start_d = 1'b0;
        dead_d        = 1'b0;
        new_frame     = 1'b0;

        // The latch follows clockwise except while driving or in the dead gap, where the reversal is pending.
        if ((state_q == S_RUN && state_d == S_RUN) || state_q == S_DEAD) begin
            dir_d = dir_q;
        end

        case (state_d)
            S_RUN: begin
                presc_d    = presc_q + 1'b1;
                slot_d     = slot_q;
                duty_eff_d = duty_eff_q;
                if (state_q != S_RUN) begin
                    new_frame = 1'b1;
                end else if (slot_end) begin
                    presc_d = '0;
                    if (slot_q == SLOT_LAST) begin
                        new_frame = 1'b1;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                if (new_frame) begin
                    presc_d    = '0;
                    slot_d     = '0;
                    period_d   = period;
                    duty_eff_d = ramped;
                end
                frame_start_d = new_frame;
                if (slot_d < duty_eff_d) begin
                    motor_d = dir_d ? 2'b01 : 2'b10;
                end
            end
            S_BRAKE: motor_d = 2'b11;
            S_DEAD: begin
                dead_d     = 1'b1;
                dead_cnt_d = (state_q == S_DEAD) ? (dead_cnt_q - 1'b1) : DEAD_LOAD;
            end
            default: ;
        endcase
    end

    assign motor_a     = motor_q[1];
    assign motor_b     = motor_q[0];
    assign duty_eff    = duty_eff_q;
    assign frame_start = frame_start_q;
    assign dead        = dead_q;

endmodule

// File: tb/tb_pwm_hbridge_ramp.sv
// Bench for pwm_hbridge_ramp: two instances (no ramp / ramp 8) against a frame-time model, plus directed literals.
module tb_pwm_hbridge_ramp;

    localparam int PS = 1;
    localparam int DC = 16;
    localparam int M_OFF = 0, M_RUN = 1, M_BRK = 2, M_DEAD = 3;

    logic       clk;
    logic       n_reset, power, clockwise, n_brake;
    logic [7:0] period, duty;
    logic [1:0] ma, mb, fs, dd;
    logic [7:0] de0, de1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pwm_hbridge_ramp #(.WIDTH(8), .PRESCALE(PS), .RAMP_STEP(0), .DEAD_CYCLES(DC)) u0 (
        .clk(clk), .n_reset(n_reset), .power(power), .clockwise(clockwise), .n_brake(n_brake),
        .period(period), .duty(duty), .motor_a(ma[0]), .motor_b(mb[0]), .duty_eff(de0),
        .frame_start(fs[0]), .dead(dd[0]));

    pwm_hbridge_ramp #(.WIDTH(8), .PRESCALE(PS), .RAMP_STEP(8), .DEAD_CYCLES(DC)) u1 (
        .clk(clk), .n_reset(n_reset), .power(power), .clockwise(clockwise), .n_brake(n_brake),
        .period(period), .duty(duty), .motor_a(ma[1]), .motor_b(mb[1]), .duty_eff(de1),
        .frame_start(fs[1]), .dead(dd[1]));

    function automatic logic [1:0] mot(int k);
        return {ma[k], mb[k]};
    endfunction

    function automatic logic [7:0] deff(int k);
        return (k == 0) ? de0 : de1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: frame position as elapsed clocks; on-time is duty_eff * slot length.
    int m_mode[2], m_t[2], m_flen[2], m_slot[2], m_de[2], m_dn[2];
    bit m_dir[2];
    int e_mot[2], e_de[2];
    bit e_fs[2], e_dead[2];
    int rs[2] = '{0, 8};

    function automatic int ramp(int cur, int tgt, int step);
        int d;
        if (step == 0) return tgt;
        d = (tgt > cur) ? tgt - cur : cur - tgt;
        if (d > step) d = step;
        return (tgt > cur) ? cur + d : cur - d;
    endfunction

    always @(posedge clk or negedge n_reset) begin
        bit nf;
        for (int k = 0; k < 2; k++) begin
            if (!n_reset) begin
                m_mode[k] = M_OFF; m_t[k] = 0; m_de[k] = 0; m_dn[k] = 0;
                e_mot[k] = 0; e_de[k] = 0; e_fs[k] = 0; e_dead[k] = 0;
            end else begin
                nf = 0;
                if (!power) begin
                    m_mode[k] = M_OFF; m_de[k] = 0; m_dir[k] = clockwise;
                end else if (!n_brake) begin
                    m_mode[k] = M_BRK; m_de[k] = 0; m_dir[k] = clockwise;
                end else if (m_mode[k] == M_RUN && clockwise != m_dir[k]) begin
                    m_mode[k] = M_DEAD; m_dn[k] = 1; m_de[k] = 0; m_dir[k] = clockwise;
                end else if (m_mode[k] == M_DEAD) begin
                    if (m_dn[k] == DC) nf = 1;
                    else m_dn[k]++;
                end else if (m_mode[k] == M_RUN) begin
                    m_t[k]++;
                    if (m_t[k] == m_flen[k]) nf = 1;
                end else begin
                    nf = 1; m_dir[k] = clockwise;
                end
                if (nf) begin
                    m_mode[k] = M_RUN;
                    m_t[k]    = 0;
                    m_slot[k] = ((period == 0) ? 1 : int'(period)) * PS;
                    m_flen[k] = 255 * m_slot[k];
                    m_de[k]   = ramp(m_de[k], int'(duty), rs[k]);
                end
                e_fs[k]   = nf;
                e_dead[k] = (m_mode[k] == M_DEAD);
                e_de[k]   = m_de[k];
                if (m_mode[k] == M_BRK) e_mot[k] = 3;
                else if (m_mode[k] == M_RUN && m_t[k] < m_de[k] * m_slot[k]) e_mot[k] = m_dir[k] ? 1 : 2;
                else e_mot[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_motor%0d", k), 32'(mot(k)), 32'(e_mot[k]));
                chk($sformatf("model_duty_eff%0d", k), 32'(deff(k)), 32'(e_de[k]));
                chk($sformatf("model_frame_start%0d", k), 32'(fs[k]), 32'(e_fs[k]));
                chk($sformatf("model_dead%0d", k), 32'(dd[k]), 32'(e_dead[k]));
            end
        end
    end

    task automatic wait_fs(int k, int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (fs[k]) break;
        end
        chk($sformatf("frame_start_seen%0d", k), 32'(fs[k]), 32'd1);
    endtask

    // Starts on a frame_start cycle, stops on the next one.
    task automatic measure(int k, logic [1:0] pat, output int on, output int len);
        on = 0; len = 0;
        do begin
            if (mot(k) == pat) on++;
            len++;
            @(negedge clk);
        end while (!fs[k] && len < 2000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int on, len, cnt, fsc;
        int ramp_exp[7] = '{8, 16, 24, 32, 32, 24, 20};

        power = 0; clockwise = 1; n_brake = 1; period = 8'd2; duty = 8'd127; n_reset = 1;
        #2 n_reset = 0;
        chk_en = 1;
        #1 chk("reset_duty_eff", 32'(de1), 32'd0);
        chk("reset_motor", 32'(mot(0)), 32'd0);
        repeat (3) @(negedge clk);
        n_reset = 1;

        fsc = 0;
        repeat (20) begin
            @(negedge clk);
            fsc += int'(fs[0]) + int'(fs[1]);
        end
        chk("off_no_frame_start", 32'(fsc), 32'd0);

        power = 1;
        wait_fs(0, 5);
        measure(0, 2'b01, on, len);
        chk("noramp_on_clocks", 32'(on), 32'd254);
        chk("noramp_frame_len", 32'(len), 32'd510);

        power = 0; duty = 8'd32;
        @(negedge clk);
        power = 1;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) duty = 8'd20;
            wait_fs(1, 600);
            chk($sformatf("ramp_frame%0d", i + 1), 32'(de1), 32'(ramp_exp[i]));
        end

        duty = 8'd255;
        wait_fs(0, 600);
        repeat (10) @(negedge clk);
        chk("pre_reverse_drive", 32'(mot(0)), 32'd1);
        clockwise = 0;
        @(negedge clk);
        chk("reverse_out", 32'(mot(0)), 32'd0);
        cnt = 0;
        while (dd[0] && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("dead_clocks", 32'(cnt), 32'd16);
        chk("post_dead_acw", 32'(mot(0)), 32'd2);
        chk("post_dead_ramp_start", 32'(de1), 32'd8);
        chk("post_dead_frame_start", 32'(fs[1]), 32'd1);

        repeat (37) @(negedge clk);
        n_brake = 0;
        @(negedge clk);
        chk("brake_out", 32'(mot(0)), 32'd3);
        chk("brake_duty_eff", 32'(de0), 32'd0);
        repeat (5) @(negedge clk);
        n_brake = 1;
        @(negedge clk);
        chk("brake_release_frame", 32'(fs[0]), 32'd1);
        chk("brake_release_out", 32'(mot(0)), 32'd2);
        repeat (5) @(negedge clk);
        clockwise = 1;
        repeat (4) @(negedge clk);
        chk("dead_before_brake", 32'(dd[0]), 32'd1);
        n_brake = 0;
        @(negedge clk);
        chk("brake_in_dead_out", 32'(mot(0)), 32'd3);
        chk("brake_in_dead_flag", 32'(dd[0]), 32'd0);

        period = 8'd0; duty = 8'd0; n_brake = 1;
        @(negedge clk);
        measure(0, 2'b00, on, len);
        chk("duty0_idle_clocks", 32'(on), 32'd255);
        chk("period0_frame_len", 32'(len), 32'd255);
        duty = 8'd255;
        wait_fs(0, 600);
        measure(0, 2'b01, on, len);
        chk("duty255_drive_clocks", 32'(on), 32'd255);

        repeat (100) @(negedge clk);
        #3 n_reset = 0;
        #1 chk("midframe_reset_out", 32'(mot(0)), 32'd0);
        chk("midframe_reset_duty_eff", 32'(de0), 32'd0);
        @(negedge clk);
        n_reset = 1;

        repeat (4000) begin
            @(negedge clk);
            power   = ($urandom_range(0, 199) != 0);
            n_brake = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 99) == 0) clockwise = ~clockwise;
            if ($urandom_range(0, 63) == 0) period = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0:       duty = 8'd0;
                    1:       duty = 8'd255;
                    default: duty = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                #3 n_reset = 0;
                @(negedge clk);
                n_reset = 1;
            end
        end

        @(negedge clk);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
